// File: rtl/montmul_rr_sched_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// montmul_rr_sched_if
//
// Bundles every signal between the Montgomery-multiplier scheduler and its
// environment: the requester handshake, the modulus configuration port, the
// shared multiplier datapath and the tagged result return.
//
// Signals (direction as seen from the scheduler, i.e. the slave modport):
//   req_valid  in   [NREQ]        per-requester operation request
//   req_ready  out  [NREQ]        per-requester grant, at most one bit high
//   req_a/b    in   [NREQ*WIDTH]  operands, requester i at [i*WIDTH +: WIDTH]
//   cfg_we     in                 single-cycle modulus write request
//   cfg_q/qp   in   [WIDTH]       new Q and Q' = -Q^-1 mod 2^WIDTH
//   cfg_busy   out                modulus change pending or never loaded
//   mm_a/b     out  [WIDTH]       registered operands to the multiplier
//   mm_q/qp    out  [WIDTH]       registered modulus to the multiplier
//   mm_res     in   [WIDTH]       multiplier result
//   rsp_valid  out  [NREQ]        one-hot result strobe
//   rsp_data   out  [WIDTH]       result, equal to mm_res
//
// Modports: slave = scheduler, master = requesters + multiplier side.
// -----------------------------------------------------------------------------
interface montmul_rr_sched_if #(
    parameter int WIDTH = 24,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  cfg_we;
    logic [WIDTH-1:0]      cfg_q;
    logic [WIDTH-1:0]      cfg_qp;
    logic                  cfg_busy;
    logic [WIDTH-1:0]      mm_a;
    logic [WIDTH-1:0]      mm_b;
    logic [WIDTH-1:0]      mm_q;
    logic [WIDTH-1:0]      mm_qp;
    logic [WIDTH-1:0]      mm_res;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;

    modport slave (
        input  req_valid, req_a, req_b, cfg_we, cfg_q, cfg_qp, mm_res,
        output req_ready, cfg_busy, mm_a, mm_b, mm_q, mm_qp, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_a, req_b, cfg_we, cfg_q, cfg_qp, mm_res,
        input  req_ready, cfg_busy, mm_a, mm_b, mm_q, mm_qp, rsp_valid, rsp_data
    );
endinterface

// File: rtl/montmul_rr_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// montmul_rr_sched
//
// Shares one fully pipelined Montgomery multiplier (one op per clock, fixed
// latency LAT) between NREQ requesters with round-robin arbitration. Owns the
// multiplier modulus (mm_q/mm_qp) and only swaps it once every in-flight
// operation has left the pipe. Each issued op carries a {valid, id} tag down a
// LAT+1 stage pipe so the result is strobed back to the requester that issued it.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   bus          montmul_rr_sched_if.slave (handshake, config, multiplier, results)
//   stat_issued  [31:0] accepted ops (only with MONTMUL_SCHED_STATS_EN)
//   stat_stall   [31:0] cycles with a request but no accept
//                       (only with MONTMUL_SCHED_STATS_EN)
//
// Optional feature: define MONTMUL_SCHED_STATS_EN to add the two counters.
// -----------------------------------------------------------------------------
module montmul_rr_sched #(
    parameter int WIDTH = 24,
    parameter int NREQ  = 4,
    parameter int LAT   = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef MONTMUL_SCHED_STATS_EN
    output logic [31:0]        stat_issued,
    output logic [31:0]        stat_stall,
`endif
    montmul_rr_sched_if.slave  bus
);
    localparam int ID_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_UNCFG,   // no modulus loaded since reset
        ST_RUN,     // issuing
        ST_DRAIN,   // modulus change pending, waiting for the pipe to empty
        ST_LOAD     // one cycle: copy shadow modulus to the multiplier
    } state_e;

    state_e            state_q, state_d;
    logic              issue_en;
    logic              shadow_we;
    logic              load_en;
    logic              busy;

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    logic              accept;

    logic [WIDTH-1:0]  mm_a_q, mm_b_q;
    logic [WIDTH-1:0]  modq_q, modqp_q;
    logic [WIDTH-1:0]  shadow_q_q, shadow_qp_q;

    logic [LAT:0]      tag_vld_q;
    logic [ID_W-1:0]   tag_id_q [LAT+1];

    // (base + ofs) mod NREQ for base, ofs < NREQ; works for non-power-of-2 NREQ.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int ofs);
        int sum;
        sum = 32'(base) + ofs;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return ID_W'(sum);
    endfunction

    // ---------------------------------------------------------------- FSM
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_UNCFG;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each combinational output gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNCFG: if (bus.cfg_we) state_d = ST_LOAD;
            ST_RUN:   if (bus.cfg_we) state_d = ST_DRAIN;
            // No issue happens in DRAIN, so the pipe is empty after this edge
            // exactly when every stage that will shift forward is invalid.
            ST_DRAIN: if (~|tag_vld_q[LAT-1:0]) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_RUN;
            default:  state_d = ST_UNCFG;
        endcase
    end

    always_comb begin
        issue_en  = 1'b0;
        shadow_we = 1'b0;
        load_en   = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_UNCFG: shadow_we = bus.cfg_we;
            ST_RUN: begin
                issue_en  = 1'b1;
                busy      = 1'b0;
                shadow_we = bus.cfg_we;
            end
            ST_LOAD:  load_en = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------ arbiter
    // First requester with valid set, searching upward from the pointer.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (issue_en) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!grant_vld && bus.req_valid[wrap_add(ptr_q, k)]) begin
                    grant_vld = 1'b1;
                    grant_idx = wrap_add(ptr_q, k);
                end
            end
        end
    end

    // A grant is only raised for a valid requester, so grant means accept.
    assign accept = grant_vld;
    assign ptr_d  = accept ? wrap_add(grant_idx, 1) : ptr_q;

    assign bus.req_ready = grant_vld ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : '0;

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            mm_a_q      <= '0;
            mm_b_q      <= '0;
            modq_q      <= '0;
            modqp_q     <= '0;
            shadow_q_q  <= '0;
            shadow_qp_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            // Operands hold when nothing is issued; the invalid tag hides the result.
            if (accept) begin
                mm_a_q <= bus.req_a[grant_idx*WIDTH +: WIDTH];
                mm_b_q <= bus.req_b[grant_idx*WIDTH +: WIDTH];
            end
            if (shadow_we) begin
                shadow_q_q  <= bus.cfg_q;
                shadow_qp_q <= bus.cfg_qp;
            end
            if (load_en) begin
                modq_q  <= shadow_q_q;
                modqp_q <= shadow_qp_q;
            end
        end
    end

    assign bus.mm_a     = mm_a_q;
    assign bus.mm_b     = mm_b_q;
    assign bus.mm_q     = modq_q;
    assign bus.mm_qp    = modqp_q;
    assign bus.cfg_busy = busy;

    // ----------------------------------------------------------- tag pipe
    // Stage 0 is entered on the accept edge; stage LAT lines up with mm_res.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[LAT-1:0], accept};
        end
    end

    // NOTE: only the valid bits need a reset; an id is never looked at while
    // its valid bit is clear, so the id shift register is left unreset.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= grant_idx;
        for (int s = 1; s <= LAT; s++) begin
            tag_id_q[s] <= tag_id_q[s-1];
        end
    end

    assign bus.rsp_valid = tag_vld_q[LAT] ? ({{(NREQ-1){1'b0}}, 1'b1} << tag_id_q[LAT]) : '0;
    assign bus.rsp_data  = bus.mm_res;

    // ---------------------------------------------------------- counters
`ifdef MONTMUL_SCHED_STATS_EN
    logic [31:0] stat_issued_q;
    logic [31:0] stat_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (accept) begin
                stat_issued_q <= stat_issued_q + 32'd1;
            end
            if ((|bus.req_valid) && !accept) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_montmul_rr_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_montmul_rr_sched
//
// Drives montmul_rr_sched through its interface with a behavioural Montgomery
// multiplier attached. Expected grants come from a small model of the arbiter
// and config state machine; expected results are pushed to a scoreboard queue
// at issue time and popped when the DUT strobes rsp_valid.
// -----------------------------------------------------------------------------
module tb_montmul_rr_sched;
    localparam int WIDTH = 24;
    localparam int NREQ  = 4;
    localparam int LAT   = 4;

    localparam int unsigned Q1 = 8380417;
    localparam int unsigned Q2 = 12289;
    localparam int unsigned Q3 = 7681;

    localparam int M_UNCFG = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_LOAD  = 3;

    typedef struct {
        logic [NREQ-1:0]  onehot;
        logic [WIDTH-1:0] data;
        int               cycle;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    montmul_rr_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

`ifdef MONTMUL_SCHED_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_stall;
`endif

    montmul_rr_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef MONTMUL_SCHED_STATS_EN
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    exp_t sb_q[$];
    exp_t mon_e;

    // Bench-side model of the scheduler control state.
    int               m_state;
    int               m_ptr;
    int               m_last;
    int unsigned      m_q;
    int unsigned      m_shadow;
    logic [NREQ-1:0]  last_ready;
    logic [WIDTH-1:0] op_a [NREQ];
    logic [WIDTH-1:0] op_b [NREQ];

    task automatic check(input string tag, input longint unsigned actual,
                         input longint unsigned expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Q' = -Q^-1 mod 2^WIDTH via Newton iteration on the 2-adic inverse.
    function automatic logic [WIDTH-1:0] calc_qp(input longint unsigned q);
        longint unsigned x;
        x = q;
        for (int i = 0; i < 5; i++) begin
            x = x * (64'd2 - q * x);
        end
        return WIDTH'(64'd0 - x);
    endfunction

    // Golden a*b*2^-WIDTH mod q by repeated modular halving.
    function automatic logic [WIDTH-1:0] exp_mont(input longint unsigned a, input longint unsigned b,
                                                  input longint unsigned q);
        longint unsigned x;
        x = (a * b) % q;
        for (int i = 0; i < WIDTH; i++) begin
            x = x[0] ? ((x + q) >> 1) : (x >> 1);
        end
        return WIDTH'(x);
    endfunction

    // Behavioural REDC multiplier using the modulus the DUT presents.
    function automatic logic [WIDTH-1:0] redc(input longint unsigned a, input longint unsigned b,
                                              input longint unsigned q, input longint unsigned qp);
        longint unsigned mask, t, m, u;
        mask = (64'd1 << WIDTH) - 64'd1;
        t = a * b;
        m = ((t & mask) * qp) & mask;
        u = (t + m * q) >> WIDTH;
        if (u >= q) u = u - q;
        return WIDTH'(u);
    endfunction

    logic [WIDTH-1:0] mul_pipe [LAT];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mul_pipe[0] <= redc(bus.mm_a, bus.mm_b, bus.mm_q, bus.mm_qp);
        for (int i = 1; i < LAT; i++) begin
            mul_pipe[i] <= mul_pipe[i-1];
        end
    end

    assign bus.mm_res = mul_pipe[LAT-1];

    // Result monitor: every strobe must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (bus.rsp_valid != '0) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", bus.rsp_valid, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_id", bus.rsp_valid, mon_e.onehot);
                check("rsp_data", bus.rsp_data, mon_e.data);
                check("rsp_cycle", cyc, mon_e.cycle);
            end
        end else if (sb_q.size() != 0 && sb_q[0].cycle <= cyc) begin
            mon_e = sb_q.pop_front();
            check("rsp_missing", 0, mon_e.onehot);
        end
    end

    task automatic model_reset();
        m_state  = M_UNCFG;
        m_ptr    = 0;
        m_last   = -1000;
        m_q      = 0;
        m_shadow = 0;
    endtask

    // One clock of stimulus: set inputs at the falling edge, check the
    // combinational grant and status, score any accept, then advance the model.
    task automatic drive_cycle(input logic [NREQ-1:0] vmask, input bit cfg,
                               input int unsigned cq, input bit rnd);
        logic [NREQ-1:0] exp_ready;
        exp_t            e;
        bit              found;
        int              g;
        int              j;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (rnd) begin
                op_a[i] = WIDTH'($urandom_range(Q2 - 1));
                op_b[i] = WIDTH'($urandom_range(Q2 - 1));
            end
            bus.req_a[i*WIDTH +: WIDTH] = op_a[i];
            bus.req_b[i*WIDTH +: WIDTH] = op_b[i];
        end
        bus.req_valid = vmask;
        bus.cfg_we    = cfg;
        bus.cfg_q     = WIDTH'(cq);
        bus.cfg_qp    = calc_qp(cq);
        #1;
        found = 1'b0;
        g     = 0;
        if (m_state == M_RUN) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (!found && vmask[j]) begin
                    found = 1'b1;
                    g     = j;
                end
            end
        end
        exp_ready = found ? (NREQ'(1) << g) : '0;
        check("req_ready", bus.req_ready, exp_ready);
        check("cfg_busy", bus.cfg_busy, (m_state != M_RUN));
        check("mm_q", bus.mm_q, m_q);
        last_ready = bus.req_ready;
        if (found) begin
            e.onehot = exp_ready;
            e.data   = exp_mont(op_a[g], op_b[g], m_q);
            e.cycle  = cyc + 1 + LAT;
            sb_q.push_back(e);
        end
        case (m_state)
            M_UNCFG: if (cfg) begin m_shadow = cq; m_state = M_LOAD; end
            M_RUN: begin
                if (found) begin
                    m_ptr  = (g + 1) % NREQ;
                    m_last = cyc + 1;
                end
                if (cfg) begin m_shadow = cq; m_state = M_DRAIN; end
            end
            M_DRAIN: if (cyc + 1 >= m_last + LAT + 1) m_state = M_LOAD;
            default: begin m_q = m_shadow; m_state = M_RUN; end
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle('0, 1'b0, 0, 1'b1);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_q     = '0;
        bus.cfg_qp    = '0;
        for (int i = 0; i < LAT; i++) mul_pipe[i] = '0;
        model_reset();

        // Power-on reset values.
        repeat (2) @(negedge clk);
        check("por_busy", bus.cfg_busy, 1);
        check("por_ready", bus.req_ready, 0);
        check("por_rsp", bus.rsp_valid, 0);
        check("por_mm_a", bus.mm_a, 0);
        check("por_mm_qp", bus.mm_qp, 0);
        rst = 1'b0;

        // Unconfigured: requests are not granted.
        repeat (2) drive_cycle('1, 1'b0, 0, 1'b1);
        drive_cycle('0, 1'b1, Q1, 1'b1);
        drive_cycle('0, 1'b0, 0, 1'b1);

        // Fairness: all requesters valid from pointer 0.
        for (int i = 0; i < 12; i++) begin
            drive_cycle('1, 1'b0, 0, 1'b1);
            check("fair_grant", last_ready, 4'b0001 << (i % 4));
        end
        idle(LAT + 2);

        // Single op from requester 2.
        op_a[2] = 24'd5;
        op_b[2] = 24'd7;
        drive_cycle(4'b0100, 1'b0, 0, 1'b0);
        check("single_grant", last_ready, 4'b0100);
        idle(LAT + 2);

        // Mid-stream modulus change; the second write lands in DRAIN and is ignored.
        for (int i = 0; i < 6; i++) drive_cycle(4'b0001, 1'b0, 0, 1'b1);
        drive_cycle(4'b0001, 1'b1, Q2, 1'b1);
        drive_cycle(4'b0001, 1'b1, Q3, 1'b1);
        for (int i = 0; i < LAT + 6; i++) drive_cycle(4'b0001, 1'b0, 0, 1'b1);
        idle(LAT + 2);
        check("new_modulus", bus.mm_q, Q2);

        // Reset mid-flight with all requesters valid and three ops in the pipe.
        repeat (3) drive_cycle('1, 1'b0, 0, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb_q.delete();
        model_reset();
        #1;
        check("rst_ready", bus.req_ready, 0);
        check("rst_rsp", bus.rsp_valid, 0);
        check("rst_busy", bus.cfg_busy, 1);
        check("rst_mm_b", bus.mm_b, 0);
        check("rst_mm_q", bus.mm_q, 0);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Three contended cycles while unconfigured, then load and issue ten ops.
        repeat (3) drive_cycle('1, 1'b0, 0, 1'b1);
        drive_cycle('0, 1'b1, Q1, 1'b1);
        drive_cycle('0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 10; i++) drive_cycle(NREQ'(1 << (i % NREQ)), 1'b0, 0, 1'b1);
        idle(LAT + 2);
`ifdef MONTMUL_SCHED_STATS_EN
        check("stat_issued", stat_issued, 10);
        check("stat_stall", stat_stall, 3);
`endif

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
